// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
//   Shared definitions for the main-memory arbiter:
//   - port IDs (fetch, data, debug, none)
//   - FSM state encoding
//   - a helper that turns a port ID into a one-hot acknowledge vector
package mem_arbiter_pkg;

    localparam logic [1:0] ARB_FETCH = 2'd0;
    localparam logic [1:0] ARB_DATA  = 2'd1;
    localparam logic [1:0] ARB_DEBUG = 2'd2;
    localparam logic [1:0] ARB_NONE  = 2'd3;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_RESP   = 2'd2
    } arb_state_e;

    // One-hot port vector for a port ID; ARB_NONE maps to all zeros.
    function automatic logic [2:0] port_onehot(input logic [1:0] id);
        logic [2:0] v;
        v = 3'b000;
        if (id != ARB_NONE) v[id] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mem_arbiter_pick.sv
// arb_pick
//   Purely combinational priority picker for the memory arbiter.
//   Ports:
//     req        in  3  per-port request level
//     starve_hit in  1  debug port has waited STARVE_LIMIT grants
//     winner     out 2  winning port ID (ARB_NONE when no request)
//     valid      out 1  at least one request present
//   Priority: data (1) > fetch (0) > debug (2), unless the starvation
//   override is active, in which case a pending debug request wins.
module arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic [2:0] req,
    input  logic       starve_hit,
    output logic [1:0] winner,
    output logic       valid
);

    always_comb begin
        winner = ARB_NONE;
        valid  = |req;
        if (starve_hit && req[2]) begin
            winner = ARB_DEBUG;
        end else if (req[1]) begin
            winner = ARB_DATA;
        end else if (req[0]) begin
            winner = ARB_FETCH;
        end else if (req[2]) begin
            winner = ARB_DEBUG;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Serialises accesses from three requesters (0 = fetch, 1 = data,
//   2 = debug/loader) onto a single-port memory, holding mem_en for
//   LATENCY cycles per access and pulsing ack to the served port.
//   Ports:
//     clk, rst_n            clock, async active-low reset
//     req/we [2:0]          per-port request level / write enable
//     addr, wdata           per-port address / write data, packed by port
//     ack [2:0]             one-cycle pulse to the served port
//     rdata                 data of the last completed read
//     busy                  high in ACCESS and RESP
//     grant_id              port being served, 3 when idle
//     mem_en/mem_we/...     memory strobe, write strobe, address, data
//     mem_rdata             memory read data (valid in last ACCESS cycle)
//     state_dbg             current FSM state, for observation
//   Handshake: a port holds req high until it sees its ack pulse; the
//   access parameters are sampled only at the granting edge, and the
//   ack cycle ignores req so a held request re-arbitrates one cycle later.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 16,
    parameter int LATENCY      = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [2:0]          req,
    input  logic [2:0]          we,
    input  logic [3*ADDR_W-1:0] addr,
    input  logic [3*DATA_W-1:0] wdata,
    output logic [2:0]          ack,
    output logic [DATA_W-1:0]   rdata,
    output logic                busy,
    output logic [1:0]          grant_id,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    output arb_state_e          state_dbg
);

    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(LATENCY - 1);
    localparam logic [STV_W-1:0] STV_LIMIT = STV_W'(STARVE_LIMIT);

    arb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [STV_W-1:0]  starve_q, starve_d;
    logic [1:0]        grant_q, grant_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic [1:0] winner;
    logic       win_valid;
    logic       starve_hit;

    assign starve_hit = (starve_q == STV_LIMIT);

    arb_pick u_pick (
        .req        (req),
        .starve_hit (starve_hit),
        .winner     (winner),
        .valid      (win_valid)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        starve_d = starve_q;
        grant_d  = grant_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;

        case (state_q)
            ARB_IDLE: begin
                if (win_valid) begin
                    state_d = ARB_ACCESS;
                    grant_d = winner;
                    cnt_d   = CNT_LOAD;
                    we_d    = we[winner];
                    addr_d  = addr[int'(winner)*ADDR_W +: ADDR_W];
                    wdata_d = wdata[int'(winner)*DATA_W +: DATA_W];
                end
            end
            ARB_ACCESS: begin
                if (cnt_q == '0) begin
                    if (!we_q) rdata_d = mem_rdata;
                    state_d = ARB_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ARB_RESP: begin
                state_d = ARB_IDLE;
                grant_d = ARB_NONE;
            end
            default: begin
                state_d = ARB_IDLE;
                grant_d = ARB_NONE;
            end
        endcase

        // The starve count only means something while debug is waiting:
        // it clears whenever debug is not requesting or is itself granted.
        if (!req[2]) begin
            starve_d = '0;
        end else if (state_q == ARB_IDLE && win_valid) begin
            if (winner == ARB_DEBUG) begin
                starve_d = '0;
            end else if (starve_q != STV_LIMIT) begin
                starve_d = starve_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ARB_IDLE;
            cnt_q    <= '0;
            starve_q <= '0;
            grant_q  <= ARB_NONE;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            starve_q <= starve_d;
            grant_q  <= grant_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
        end
    end

    // Strobes decode straight from the state register so an async reset
    // drops them in the same instant.
    assign mem_en    = (state_q == ARB_ACCESS);
    assign mem_we    = mem_en & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign ack       = (state_q == ARB_RESP) ? port_onehot(grant_q) : 3'b000;
    assign rdata     = rdata_q;
    assign busy      = (state_q != ARB_IDLE);
    assign grant_id  = grant_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed bench for mem_arbiter with LATENCY = 3, STARVE_LIMIT = 4.
//   Expected ack responses (port + rdata) are queued at issue time and
//   popped by a monitor on every ack pulse; timing and strobe behaviour
//   are checked inline by the stimulus process.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int AW  = 8;
    localparam int DW  = 16;
    localparam int LAT = 3;
    localparam int SL  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [2:0]        req = '0;
    logic [2:0]        we = '0;
    logic [3*AW-1:0]   addr = '0;
    logic [3*DW-1:0]   wdata = '0;
    logic [2:0]        ack;
    logic [DW-1:0]     rdata;
    logic              busy;
    logic [1:0]        grant_id;
    logic              mem_en;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [DW-1:0]     mem_rdata;
    arb_state_e        state_dbg;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [DW+1:0] exp_q[$];
    logic [DW+1:0] mon_e;
    logic [DW-1:0] mem [256];

    mem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .LATENCY(LAT), .STARVE_LIMIT(SL)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .ack       (ack),
        .rdata     (rdata),
        .busy      (busy),
        .grant_id  (grant_id),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / cycle count ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- memory model ----------------
    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        case (a)
            8'h10:   return 16'hBEEF;
            8'h30:   return 16'hAAAA;
            8'h40:   return 16'h5555;
            8'h51:   return 16'hC0DE;
            8'h52:   return 16'hD00D;
            8'h60:   return 16'h6060;
            8'h70:   return 16'h7070;
            default: return 16'h0000;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(AW'(i));
        end else if (mem_en && mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    assign mem_rdata = mem[mem_addr];

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input logic [1:0] port, input logic [DW-1:0] data);
        exp_q.push_back({port, data});
    endtask

    task automatic set_port(input int p, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        we[p] = w;
        addr[p*AW +: AW] = a;
        wdata[p*DW +: DW] = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for ack[p]; returns at the negedge of the ack cycle.
    task automatic wait_ack(input int p, output int at);
        bit seen;
        seen = 1'b0;
        at = -1;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (ack[p]) begin
                seen = 1'b1;
                at = cyc;
            end
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL ack_timeout: port %0d got no ack within 40 cycles", p);
        end
    endtask

    task automatic wait_any(output logic [2:0] a);
        a = 3'b000;
        for (int k = 0; k < 40 && a == 3'b000; k++) begin
            @(negedge clk);
            a = ack;
        end
        if (a == 3'b000) begin
            n_checks++;
            n_fail++;
            $display("FAIL ack_timeout: no ack within 40 cycles");
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            n_checks++;
            if (mem_we && !mem_en) begin
                n_fail++;
                $display("FAIL mem_we_qualified: mem_we=1 with mem_en=0 (cycle %0d)", cyc);
            end
        end
        if (ack !== 3'b000 && rst_n === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_ack: got ack %b, expected none (cycle %0d)", ack, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("ack_port", {29'd0, ack}, {29'd0, 3'b001 << mon_e[DW+1:DW]});
                check("ack_rdata", {16'd0, rdata}, {16'd0, mon_e[DW-1:0]});
            end
        end
        if (rst_n === 1'b0 && ack !== 3'b000) begin
            n_checks++;
            n_fail++;
            $display("FAIL ack_in_reset: got ack %b, expected 000", ack);
        end
    end

    // ---------------- stimulus ----------------
    int t_a;
    int t_b;
    logic [2:0] got;
    int ord[6] = '{1, 1, 1, 1, 2, 1};

    initial begin
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("rst_ack", {29'd0, ack}, 32'd0);
        check("rst_rdata", {16'd0, rdata}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_grant_id", {30'd0, grant_id}, 32'd3);
        check("rst_mem_en", {31'd0, mem_en}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
        check("rst_mem_wdata", {16'd0, mem_wdata}, 32'd0);
        check("rst_state", {30'd0, state_dbg}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // --- single read, port 0 ---
        set_port(0, 1'b0, 8'h10, 16'h0000);
        req = 3'b001;
        push_exp(2'd0, 16'hBEEF);
        @(posedge clk);
        for (int k = 0; k < LAT; k++) begin
            @(negedge clk);
            check("rd_mem_en", {31'd0, mem_en}, 32'd1);
            check("rd_mem_we", {31'd0, mem_we}, 32'd0);
            check("rd_mem_addr", {24'd0, mem_addr}, 32'h10);
            check("rd_grant_id", {30'd0, grant_id}, 32'd0);
            check("rd_no_ack_yet", {29'd0, ack}, 32'd0);
        end
        @(negedge clk);
        check("rd_ack", {29'd0, ack}, 32'b001);
        check("rd_mem_en_off", {31'd0, mem_en}, 32'd0);
        check("rd_grant_in_resp", {30'd0, grant_id}, 32'd0);
        tick();
        req = 3'b000;
        @(negedge clk);
        check("rd_idle_grant", {30'd0, grant_id}, 32'd3);
        check("rd_idle_busy", {31'd0, busy}, 32'd0);

        // --- write, port 1 ---
        tick();
        set_port(1, 1'b1, 8'h20, 16'h1234);
        req = 3'b010;
        push_exp(2'd1, 16'hBEEF);
        @(posedge clk);
        for (int k = 0; k < LAT; k++) begin
            @(negedge clk);
            check("wr_mem_en", {31'd0, mem_en}, 32'd1);
            check("wr_mem_we", {31'd0, mem_we}, 32'd1);
            check("wr_mem_addr", {24'd0, mem_addr}, 32'h20);
            check("wr_mem_wdata", {16'd0, mem_wdata}, 32'h1234);
            if (k == 0) begin
                // changing the request after grant must not disturb the access
                set_port(1, 1'b0, 8'hFF, 16'hFFFF);
            end
        end
        @(negedge clk);
        check("wr_ack", {29'd0, ack}, 32'b010);
        check("wr_mem", {16'd0, mem[8'h20]}, 32'h1234);
        check("wr_rdata_kept", {16'd0, rdata}, 32'hBEEF);
        tick();
        req = 3'b000;

        // --- contention: data beats fetch ---
        tick();
        set_port(0, 1'b0, 8'h40, 16'h0000);
        set_port(1, 1'b0, 8'h30, 16'h0000);
        req = 3'b011;
        push_exp(2'd1, 16'hAAAA);
        push_exp(2'd0, 16'h5555);
        wait_ack(1, t_a);
        tick();
        req[1] = 1'b0;
        wait_ack(0, t_b);
        check("contention_gap", t_b - t_a, LAT + 2);
        tick();
        req = 3'b000;

        // --- starvation override ---
        tick();
        set_port(0, 1'b0, 8'h50, 16'h0000);
        set_port(1, 1'b0, 8'h51, 16'h0000);
        set_port(2, 1'b0, 8'h52, 16'h0000);
        req = 3'b111;
        for (int i = 0; i < 6; i++) push_exp(2'(ord[i]), (ord[i] == 2) ? 16'hD00D : 16'hC0DE);
        for (int i = 0; i < 6; i++) begin
            wait_any(got);
            check("starve_order", {29'd0, got}, {29'd0, 3'b001 << ord[i]});
        end
        tick();
        req = 3'b000;

        // --- reset during ACCESS ---
        tick();
        set_port(0, 1'b0, 8'h60, 16'h0000);
        req = 3'b001;
        push_exp(2'd0, 16'h6060);
        @(posedge clk);
        @(negedge clk);
        check("mid_first_access", {31'd0, mem_en}, 32'd1);
        tick();
        rst_n = 1'b0;
        #1;
        check("mid_rst_mem_en", {31'd0, mem_en}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_grant", {30'd0, grant_id}, 32'd3);
        check("mid_rst_ack", {29'd0, ack}, 32'd0);
        check("mid_rst_rdata", {16'd0, rdata}, 32'd0);
        repeat (2) @(negedge clk);
        tick();
        rst_n = 1'b1;
        wait_ack(0, t_a);
        tick();
        req = 3'b000;

        // --- request dropped during ACCESS ---
        tick();
        set_port(0, 1'b0, 8'h70, 16'h0000);
        req = 3'b001;
        push_exp(2'd0, 16'h7070);
        tick();
        req = 3'b000;
        wait_ack(0, t_a);
        @(negedge clk);
        check("drop_idle_grant", {30'd0, grant_id}, 32'd3);
        check("drop_idle_busy", {31'd0, busy}, 32'd0);
        repeat (LAT + 2) @(negedge clk);
        check("drop_still_idle", {30'd0, state_dbg}, 32'd0);

        check("queue_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
